sync_debounce_bank: RTL and testbench

- Parametrised multi-channel input conditioner; the next generation of the controller's single-bit input synchronizer.
- Takes N_CH asynchronous inputs (sensor, walk request, reprogram, spares) and passes each through a configurable-depth synchronizer chain and a per-channel debounce filter.
- Produces clean level outputs, single-cycle rise and fall pulses, and optional sticky request latches.
- Sits between the board pins and the traffic-light FSM; the FSM consumes only this block's outputs.

---
 rtl/sync_debounce_bank.sv | 72 +++++++
 tb/tb_sync_debounce_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - multi-channel synchronizer, debounce filter, edge pulses and sticky request latches
module sync_debounce_bank #(
  parameter int                N_CH        = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                DB_CYCLES   = 16,
  parameter logic [N_CH-1:0]   LATCH_MASK  = 'b0010
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic [N_CH-1:0] Async_In,
  input  logic [N_CH-1:0] Clear,
  output logic [N_CH-1:0] Sync_Out,
  output logic [N_CH-1:0] Rise_Pulse,
  output logic [N_CH-1:0] Fall_Pulse,
  output logic [N_CH-1:0] Latched
);

  localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] stage;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   q;
    logic                   rise;
    logic                   fall;
    logic                   latch;
    logic                   accept;

    always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
        stage <= '0;
      end else begin
        stage <= {stage[SYNC_STAGES-2:0], Async_In[i]};
      end
    end

    assign s      = stage[SYNC_STAGES-1];
    assign accept = (s != q) && (cnt == CNT_MAX);

    // cnt counts consecutive cycles the synchronized level has disagreed with q
    always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
        q     <= 1'b0;
        cnt   <= '0;
        rise  <= 1'b0;
        fall  <= 1'b0;
        latch <= 1'b0;
      end else begin
        if (s == q) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          q   <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        rise  <= accept & s;
        fall  <= accept & ~s;
        // set beats clear so a request arriving with Clear is never lost
        latch <= LATCH_MASK[i] & ((accept & s) | (latch & ~Clear[i]));
      end
    end

    assign Sync_Out[i]   = q;
    assign Rise_Pulse[i] = rise;
    assign Fall_Pulse[i] = fall;
    assign Latched[i]    = latch;
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - self-checking bench for sync_debounce_bank
module tb_sync_debounce_bank;

  localparam int         N    = 4;
  localparam int         SYNC = 2;
  localparam int         DB   = 4;
  localparam logic [3:0] MASK = 4'b0010;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Async_In;
  logic [3:0] Clear;
  logic [3:0] Sync_Out;
  logic [3:0] Rise_Pulse;
  logic [3:0] Fall_Pulse;
  logic [3:0] Latched;

  always #5 clk = ~clk;

  sync_debounce_bank #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LATCH_MASK(MASK)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .Async_In(Async_In), .Clear(Clear),
    .Sync_Out(Sync_Out), .Rise_Pulse(Rise_Pulse), .Fall_Pulse(Fall_Pulse), .Latched(Latched)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] c;
    logic [3:0] sync;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] latch;
  } vec_t;

  vec_t tbl [14];

  int vectors = 0;
  int miscompares = 0;

  // reference: input history per edge; a level is accepted once DB consecutive
  // synchronized samples differ from the current output level
  logic [3:0] hist [$];
  logic [3:0] s_hist [$];
  logic [3:0] m_q, m_rise, m_fall, m_latch;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    s_hist.delete();
    m_q = '0; m_rise = '0; m_fall = '0; m_latch = '0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [3:0] c);
    logic [3:0] s;
    int n;
    hist.push_back(a);
    n = hist.size();
    s = (n > SYNC) ? hist[n-1-SYNC] : 4'h0;
    s_hist.push_back(s);
    n = s_hist.size();
    for (int ch = 0; ch < N; ch++) begin
      logic v, same, acc;
      v = s[ch];
      acc = 1'b0;
      if (n >= DB) begin
        same = 1'b1;
        for (int k = 0; k < DB; k++) if (s_hist[n-1-k][ch] != v) same = 1'b0;
        acc = same && (v != m_q[ch]);
      end
      m_rise[ch] = acc && v;
      m_fall[ch] = acc && !v;
      if (acc) m_q[ch] = v;
      if (MASK[ch]) begin
        if (acc && v) m_latch[ch] = 1'b1;
        else if (c[ch]) m_latch[ch] = 1'b0;
      end
    end
    while (hist.size() > 8) void'(hist.pop_front());
    while (s_hist.size() > 8) void'(s_hist.pop_front());
  endtask

  task automatic tick(input logic [3:0] a, input logic [3:0] c, input string name);
    Async_In = a;
    Clear = c;
    @(posedge clk);
    model_edge(a, c);
    #1;
    check(name, {Sync_Out, Rise_Pulse, Fall_Pulse, Latched}, {m_q, m_rise, m_fall, m_latch});
  endtask

  // asserts reset between edges and checks outputs clear without a clock edge
  task automatic mid_reset(input string name);
    #3;
    Reset_n = 1'b0;
    #1;
    check(name, {Sync_Out, Rise_Pulse, Fall_Pulse, Latched}, 16'h0);
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;
    logic [3:0] tgt;
    logic       seen;
    logic [3:0] other_latch;

    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[6]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    Reset_n = 1'b0;
    Async_In = '0;
    Clear = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {Sync_Out, Rise_Pulse, Fall_Pulse, Latched}, 16'h0);
    Reset_n = 1'b1;

    // 1: fill all channels, then async reset mid-cycle
    for (int k = 0; k < 8; k++) tick(4'hf, 4'h0, "t1_fill");
    check("t1_pre_reset", {Sync_Out, Latched}, {4'hf, 4'b0010});
    mid_reset("t1_async_reset");
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      tick(4'h0, 4'h0, "t1_quiet");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse | Latched;
    end
    check("t1_quiet_all", {12'h0, acc}, 16'h0);

    // 2: clean step on channel 0, table driven
    for (int k = 0; k < 14; k++) begin
      tick(tbl[k].a, tbl[k].c, "t2_model");
      check($sformatf("t2_row%0d", k), {Sync_Out, Rise_Pulse, Fall_Pulse, Latched},
            {tbl[k].sync, tbl[k].rise, tbl[k].fall, tbl[k].latch});
    end

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted on channel 2
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      tick(4'h4, 4'h0, "t3_glitch");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse;
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'h0, 4'h0, "t3_glitch");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse;
    end
    check("t3_glitch_hidden", {15'h0, acc[2]}, 16'h0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(4'h4, 4'h0, "t3_accept");
      seen |= Rise_Pulse[2];
    end
    for (int k = 0; k < 10; k++) begin
      tick(4'h0, 4'h0, "t3_accept");
      seen |= Rise_Pulse[2];
    end
    check("t3_accept_seen", {15'h0, seen}, 16'h1);

    // 4: latch holds after the input falls, cleared by one Clear cycle
    for (int k = 0; k < 10; k++) tick(4'h2, 4'h0, "t4_high");
    for (int k = 0; k < 8; k++) tick(4'h0, 4'h0, "t4_low");
    check("t4_latch_hold", {15'h0, Latched[1]}, 16'h1);
    tick(4'h0, 4'h2, "t4_clear_edge");
    check("t4_clear", {15'h0, Latched[1]}, 16'h0);

    // 5: Clear held across the accepting edge, set wins
    for (int k = 0; k < 6; k++) tick(4'h2, 4'h2, "t5_collide");
    check("t5_set_wins", {15'h0, Latched[1]}, 16'h1);
    tick(4'h2, 4'h2, "t5_clear_after");
    for (int k = 0; k < 8; k++) tick(4'h0, 4'h0, "t5_low");

    // 6: channels 0 and 3 toggle together with different hold lengths
    acc = '0;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(4'h9, 4'h0, "t6_indep");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse;
      seen |= Rise_Pulse[0];
    end
    for (int k = 0; k < 3; k++) begin
      tick(4'h1, 4'h0, "t6_indep");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse;
      seen |= Rise_Pulse[0];
    end
    for (int k = 0; k < 10; k++) begin
      tick(4'h0, 4'h0, "t6_indep");
      acc |= Sync_Out | Rise_Pulse | Fall_Pulse;
      seen |= Rise_Pulse[0];
    end
    check("t6_ch3_unchanged", {15'h0, acc[3]}, 16'h0);
    check("t6_ch0_accepted", {15'h0, seen}, 16'h1);

    // random stimulus against the reference model
    tgt = '0;
    other_latch = '0;
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] c;
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 5) == 0) tgt[ch] = ~tgt[ch];
        c[ch] = ($urandom_range(0, 7) == 0);
      end
      tick(tgt, c, "rand");
      other_latch |= Latched & 4'b1101;
      if ($urandom_range(0, 399) == 0) mid_reset("rand_reset");
    end
    check("unlatched_channels_zero", {12'h0, other_latch}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
